pipe_skid_stage: RTL
====================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 64, giving the payload width (next-seq PC plus instruction).
REQ-002 The module SHALL have parameter CNT_SIZE, default 16, giving the stall-counter width.
REQ-003 The module SHALL use one clock, i_clk; reset i_reset SHALL be synchronous and active-high.
REQ-004 Port i_clk  in  1  stage clock.
REQ-005 Port i_reset  in  1  synchronous active-high reset.
REQ-006 Port i_flush  in  1  synchronous discard of all held entries.
REQ-007 Port i_valid  in  1  upstream entry present.
REQ-008 Port o_ready  out  1  stage can accept an entry this cycle.
REQ-009 Port i_data  in  DATA_SIZE  upstream payload.
REQ-010 Port i_halt  in  1  upstream entry is a halt marker.
REQ-011 Port o_valid  out  1  output entry present.
REQ-012 Port i_ready  in  1  downstream accepts output entry.
REQ-013 Port o_data  out  DATA_SIZE  output payload.
REQ-014 Port o_halt  out  1  output entry is a halt marker.
REQ-015 Port o_halted  out  1  sticky: halt entry accepted, intake closed.
REQ-016 Port o_occupancy  out  2  number of held entries, 0..2.
REQ-017 Port o_stall_count  out  CNT_SIZE  cycles with o_valid=1 and i_ready=0.

Function
REQ-018 The stage SHALL hold two entries: MAIN (drives o_data/o_halt/o_valid) and SKID; each entry is payload + halt bit + valid bit.
REQ-019 o_ready SHALL be 1 iff SKID is empty and o_halted=0, decoded from registered state only, with no combinational path from i_ready or i_valid.
REQ-020 Accept SHALL occur when i_valid=1 and o_ready=1; transfer SHALL occur when o_valid=1 and i_ready=1.
REQ-021 Empty stage, accept: entry SHALL appear in MAIN next cycle (latency 1).
REQ-022 MAIN full, transfer plus accept, SKID empty: new entry SHALL load MAIN; occupancy stays 1.
REQ-023 MAIN full, no transfer, accept: new entry SHALL load SKID; occupancy becomes 2.
REQ-024 Both full, transfer: SKID SHALL move into MAIN, SKID becomes empty; no accept is possible that cycle.
REQ-025 MAIN full, transfer, no accept: MAIN SHALL become empty if SKID is empty.
REQ-026 Order SHALL be strictly FIFO; no entry is dropped or duplicated except by flush or reset.
REQ-027 Accepting an entry with i_halt=1 SHALL set o_halted next cycle; o_ready then stays 0 until flush or reset; entries already held still drain normally.
REQ-028 i_flush=1 SHALL empty MAIN and SKID and clear o_halted next cycle; an accept in the same cycle SHALL be discarded; a transfer in the same cycle is still counted as taken by downstream.
REQ-029 o_data and o_halt SHALL hold their last value when MAIN is emptied by transfer; flush and reset SHALL clear them to 0.
REQ-030 o_stall_count SHALL increment by 1 each cycle o_valid=1 and i_ready=0, saturate at 2^CNT_SIZE-1, and be unaffected by flush.
REQ-031 o_occupancy SHALL equal the count of valid entries after each clock edge.

Reset
REQ-032 i_reset=1 at a clock edge SHALL set o_valid=0, o_data=0, o_halt=0, o_halted=0, o_occupancy=0, o_stall_count=0, SKID empty; o_ready=1 the following cycle.
REQ-033 Reset SHALL take priority over flush, accept and transfer in the same cycle, including mid-operation with both entries full.

Verification
REQ-034 Stream with i_ready=1: accept 0x11,0x22,0x33 on consecutive cycles -> o_data 0x11,0x22,0x33 one cycle later each, o_occupancy=1, o_stall_count=0.
REQ-035 i_ready=0, accept 0xA then 0xB -> o_occupancy=2, o_ready=0, o_stall_count increments each cycle; release i_ready -> 0xA then 0xB out, o_ready=1 after 0xA leaves.
REQ-036 Accept 0x5 with i_halt=1 -> o_halted=1, o_ready=0, o_halt=1 with 0x5; further i_valid ignored until i_flush pulse, which clears o_halted and o_valid.
REQ-037 Both entries full, i_flush=1 with i_valid=1 -> o_occupancy=0, o_valid=0, o_data=0; flushed input not delivered.
REQ-038 CNT_SIZE=2, hold i_ready=0 with o_valid=1 for 6 cycles -> o_stall_count 1,2,3,3,3,3.
REQ-039 Both entries full, i_reset=1 with i_flush=1 and i_valid=1 -> all outputs at reset values next cycle, o_ready=1.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Two-entry skid buffer for a fetch/decode pipeline boundary. MAIN drives the
//   output; SKID catches one entry when downstream stalls. o_ready is decoded
//   from registered state only, so there is no combinational path from i_ready
//   or i_valid to o_ready.
//
// Ports
//   i_clk          stage clock
//   i_reset        synchronous active-high reset (wins over everything)
//   i_flush        synchronous discard of all held entries, clears o_halted
//   i_valid/o_ready/i_data/i_halt   upstream handshake and payload
//   o_valid/i_ready/o_data/o_halt   downstream handshake and payload
//   o_halted       sticky: a halt entry was accepted, intake closed
//   o_occupancy    number of held entries (0..2)
//   o_stall_count  saturating count of cycles with o_valid=1 and i_ready=0
module pipe_skid_stage #(
    parameter int DATA_SIZE = 64,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_halt,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_halt,
    output logic                 o_halted,
    output logic [1:0]           o_occupancy,
    output logic [CNT_SIZE-1:0]  o_stall_count
);

    logic                 main_valid_q, main_valid_d;
    logic [DATA_SIZE-1:0] main_data_q,  main_data_d;
    logic                 main_halt_q,  main_halt_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [DATA_SIZE-1:0] skid_data_q,  skid_data_d;
    logic                 skid_halt_q,  skid_halt_d;
    logic                 halted_q,     halted_d;
    logic [CNT_SIZE-1:0]  stall_q,      stall_d;

    logic accept_s;
    logic xfer_s;

    // Intake is closed while SKID holds an entry or after a halt was accepted.
    assign o_ready  = ~skid_valid_q & ~halted_q;
    assign accept_s = i_valid & o_ready;
    assign xfer_s   = main_valid_q & i_ready;

    assign o_valid       = main_valid_q;
    assign o_data        = main_data_q;
    assign o_halt        = main_halt_q;
    assign o_halted      = halted_q;
    assign o_occupancy   = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign o_stall_count = stall_q;

    // Next-state for the two entries, the halt latch and the stall counter.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_halt_d  = main_halt_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_halt_d  = skid_halt_q;
        halted_d     = halted_q;
        stall_d      = stall_q;

        if (i_flush) begin
            // Flush drops everything, including any entry offered this cycle.
            main_valid_d = 1'b0;
            main_data_d  = {DATA_SIZE{1'b0}};
            main_halt_d  = 1'b0;
            skid_valid_d = 1'b0;
            skid_data_d  = {DATA_SIZE{1'b0}};
            skid_halt_d  = 1'b0;
            halted_d     = 1'b0;
        end else begin
            if (xfer_s) begin
                if (skid_valid_q) begin
                    // SKID refills MAIN; o_ready was 0 so no accept can collide.
                    main_data_d  = skid_data_q;
                    main_halt_d  = skid_halt_q;
                    skid_valid_d = 1'b0;
                end else if (accept_s) begin
                    main_data_d = i_data;
                    main_halt_d = i_halt;
                end else begin
                    // MAIN drains; data/halt keep their last value.
                    main_valid_d = 1'b0;
                end
            end else if (accept_s) begin
                if (main_valid_q) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = i_data;
                    skid_halt_d  = i_halt;
                end else begin
                    main_valid_d = 1'b1;
                    main_data_d  = i_data;
                    main_halt_d  = i_halt;
                end
            end else begin
                main_valid_d = main_valid_q;
            end

            if (accept_s && i_halt) begin
                halted_d = 1'b1;
            end else begin
                halted_d = halted_q;
            end
        end

        // Stall counting ignores flush and saturates at all-ones.
        if (main_valid_q && !i_ready && (stall_q != {CNT_SIZE{1'b1}})) begin
            stall_d = stall_q + {{(CNT_SIZE-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with synchronous reset taking priority over all traffic.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= {DATA_SIZE{1'b0}};
            main_halt_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DATA_SIZE{1'b0}};
            skid_halt_q  <= 1'b0;
            halted_q     <= 1'b0;
            stall_q      <= {CNT_SIZE{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_halt_q  <= main_halt_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_halt_q  <= skid_halt_d;
            halted_q     <= halted_d;
            stall_q      <= stall_d;
        end
    end

endmodule
